// File: rtl/mux2_rr_feeder.sv
// mux2_rr_feeder: round-robin arbiter in front of a 2:1 mux.
// It picks which of two single-bit sources drives the mux, limits how long one
// source may hold the mux while the other waits, and registers the selected
// beat into a valid/ready output stream.
module mux2_rr_feeder #(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  input  logic mux_y,
  output logic dout,
  output logic dout_vld,
  input  logic dout_rdy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] MAX_C = 4'(MAX_BURST);

  state_t     state;
  logic [3:0] cnt;
  logic       stall;
  logic       grant;
  logic       gsrc;
  logic       same_owner;

  // Burst counter increment that stops at the burst limit, so a lone
  // requester can keep the mux indefinitely without the count wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c >= MAX_C) ? MAX_C : c + 4'd1;
  endfunction

  // Grant decision: a held output register blocks all grants; otherwise
  // lone requesters win outright and contention follows the burst limit.
  always_comb begin
    stall = dout_vld & ~dout_rdy;
    grant = 1'b0;
    gsrc  = 1'b0;
    if (!rst && !stall) begin
      if (req0 && !req1) begin
        grant = 1'b1;
        gsrc  = 1'b0;
      end else if (req1 && !req0) begin
        grant = 1'b1;
        gsrc  = 1'b1;
      end else if (req0 && req1) begin
        grant = 1'b1;
        unique case (state)
          OWN0:    gsrc = (cnt >= MAX_C);
          OWN1:    gsrc = (cnt <  MAX_C);
          default: gsrc = 1'b0;
        endcase
      end
    end
  end

  assign same_owner = ((state == OWN0) && !gsrc) || ((state == OWN1) && gsrc);

  // sel is forced low whenever nothing is granted.
  assign gnt0 = grant & ~gsrc;
  assign gnt1 = grant &  gsrc;
  assign sel  = grant &  gsrc;

  // Owner, burst count and output valid: hold on stall, track grants otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      dout_vld <= 1'b0;
    end else if (!stall) begin
      if (grant) begin
        state    <= gsrc ? OWN1 : OWN0;
        cnt      <= same_owner ? sat_inc(cnt) : 4'd1;
        dout_vld <= 1'b1;
      end else begin
        state <= IDLE;
        cnt   <= 4'd0;
        if (dout_rdy) dout_vld <= 1'b0;
      end
    end
  end

  // Captured beat: mux output is sampled only in grant cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= 1'b0;
    end else if (grant) begin
      dout <= mux_y;
    end
  end

endmodule

// File: tb/tb_mux2_rr_feeder.sv
// Bench for mux2_rr_feeder: two instances (burst limit 4 and 1) share one
// stimulus stream; a queue-based grant-history model predicts every output.
module tb_mux2_rr_feeder;

  logic clk;
  logic rst, req0, req1, rdy, in0, in1;

  logic gnt0_a, gnt1_a, sel_a, y_a, dout_a, vld_a;
  logic gnt0_b, gnt1_b, sel_b, y_b, dout_b, vld_b;

  int passed = 0;
  int total  = 0;

  // Model: grants since the last idle/reset cycle, plus output register image.
  int qa[$];
  int qb[$];
  bit mdout_a = 1'b0, mvld_a = 1'b0;
  bit mdout_b = 1'b0, mvld_b = 1'b0;

  // The mux itself, one per instance.
  assign y_a = sel_a ? in1 : in0;
  assign y_b = sel_b ? in1 : in0;

  mux2_rr_feeder #(.MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .gnt0(gnt0_a), .gnt1(gnt1_a), .sel(sel_a), .mux_y(y_a),
    .dout(dout_a), .dout_vld(vld_a), .dout_rdy(rdy)
  );

  mux2_rr_feeder #(.MAX_BURST(1)) dut_b (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .sel(sel_b), .mux_y(y_b),
    .dout(dout_b), .dout_vld(vld_b), .dout_rdy(rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Length of the trailing run of identical grants, capped at the burst limit.
  function automatic int trail(input int q[$], input int mb);
    int n;
    n = 0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i] != q[q.size() - 1] || n >= mb) break;
      n++;
    end
    return n;
  endfunction

  // Which source should win this cycle (-1 = none), ignoring reset/stall.
  function automatic int pick(input int q[$], input int mb, input bit r0, input bit r1);
    int last;
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (!r0 && !r1) return -1;
    if (q.size() == 0) return 0;
    last = q[q.size() - 1];
    if (trail(q, mb) >= mb) return 1 - last;
    return last;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One clock cycle: apply inputs, check both instances, advance the model.
  task automatic step(input bit r, input bit q0, input bit q1, input bit rd,
                      input bit i0, input bit i1);
    int ga, gb;
    @(negedge clk);
    rst = r; req0 = q0; req1 = q1; rdy = rd; in0 = i0; in1 = i1;
    #1;
    ga = (r || (mvld_a && !rd)) ? -1 : pick(qa, 4, q0, q1);
    gb = (r || (mvld_b && !rd)) ? -1 : pick(qb, 1, q0, q1);
    chk("gnt0_mb4", gnt0_a, ga == 0);
    chk("gnt1_mb4", gnt1_a, ga == 1);
    chk("sel_mb4",  sel_a,  ga == 1);
    chk("vld_mb4",  vld_a,  mvld_a);
    chk("dout_mb4", dout_a, mdout_a);
    chk4("cnt_mb4", dut_a.cnt, 4'(trail(qa, 4)));
    chk("gnt0_mb1", gnt0_b, gb == 0);
    chk("gnt1_mb1", gnt1_b, gb == 1);
    chk("sel_mb1",  sel_b,  gb == 1);
    chk("vld_mb1",  vld_b,  mvld_b);
    chk("dout_mb1", dout_b, mdout_b);
    chk("onehot_mb4", gnt0_a & gnt1_a, 1'b0);
    @(posedge clk);
    if (r) begin
      qa.delete(); mdout_a = 1'b0; mvld_a = 1'b0;
      qb.delete(); mdout_b = 1'b0; mvld_b = 1'b0;
    end else begin
      if (!(mvld_a && !rd)) begin
        if (ga >= 0) begin
          qa.push_back(ga); mdout_a = (ga == 1) ? i1 : i0; mvld_a = 1'b1;
        end else begin
          qa.delete(); if (rd) mvld_a = 1'b0;
        end
      end
      if (!(mvld_b && !rd)) begin
        if (gb >= 0) begin
          qb.push_back(gb); mdout_b = (gb == 1) ? i1 : i0; mvld_b = 1'b1;
        end else begin
          qb.delete(); if (rd) mvld_b = 1'b0;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; rdy = 1'b1; in0 = 1'b0; in1 = 1'b0;

    // Reset held with both requesting.
    repeat (3) step(1, 1, 1, 1, 0, 0);

    // Contention from IDLE; in0=1/in1=0 makes the stream follow sel.
    repeat (12) step(0, 1, 1, 1, 1, 0);

    // Backpressure mid-contention, then resume.
    repeat (3) step(0, 1, 1, 0, 1, 0);
    repeat (6) step(0, 1, 1, 1, 1, 0);

    // Lone requester on source 1 with in1=1.
    repeat (10) step(0, 0, 1, 1, 0, 1);
    step(0, 0, 0, 1, 0, 0);

    // Two grants to source 1, reset mid-burst, then contention again.
    step(0, 0, 1, 1, 0, 1);
    step(0, 1, 1, 1, 0, 1);
    step(1, 1, 1, 1, 0, 1);
    repeat (6) step(0, 1, 1, 1, 1, 0);

    // Randomized traffic with occasional stalls and resets.
    repeat (400)
      step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
